etherheader_rx_parser: RTL and testbench
========================================

// Module: etherheader_rx_parser
// PURPOSE
//  Receive-side counterpart of the Ethernet TX header writer.
//  Reads the 14-byte header of a received frame from port B of the DM9000A RX
//  frame RAM and extracts the fields: destination MAC, source (PC) MAC and EtherType.
//  Checks the destination MAC against the local MAC (`MAC_Addr0..5 in DM9000A.def) and broadcast.
//  Its outputs in_from_Dm9000a_Rx_MAC_pc / _Ether_type feed the TX header writer for replies.
// PARAMETERS
//  ETHER_OFFSET  10'd0  RAM address of header byte 0
//  RD_LAT        2      RAM port-B read latency in clocks, address->q_b (1..3)
// PORTS
//  iDm9000aClk        in   1   design clock; everything is on the rising edge
//  iRunStart          in   1   asynchronous active-low reset; low=reset/idle, high=run one parse
//  iFrameLen          in   11  received frame length in bytes, stable while iRunStart=1
//  q_b                in   8   RAM port-B read data
//  rden_b             out  1   RAM port-B read enable
//  address_b          out  10  RAM port-B address
//  oRx_MAC_pc         out  48  source MAC, byte6 in [47:40] ... byte11 in [7:0]
//  oRx_Ether_type     out  16  EtherType, byte12 in [15:8], byte13 in [7:0]
//  oDestMatch         out  1   destination == local MAC
//  oBroadcast         out  1   destination == FF:FF:FF:FF:FF:FF
//  oRunErr            out  1   frame shorter than 14 bytes, no read performed
//  oRunEnd            out  1   parse finished; outputs valid
// BEHAVIOUR
//  - Reset (iRunStart low, async): State=IDLE; counters=0; address_b=0; rden_b=0.
//    All field/flag outputs = 0; oRunEnd=0. Dropping iRunStart mid-parse aborts immediately.
//  - States (one-hot):
//    IDLE -> READ if iFrameLen>=14, else -> END with oRunErr=1.
//    READ lasts exactly 14 cycles -> DRAIN.
//    DRAIN -> CHECK when the 14th byte is captured.
//    CHECK -> END after 1 cycle.
//    END holds until reset.
//  - READ: rden_b=1 (Moore). On entry address_b<=ETHER_OFFSET and it increments by 1 each edge.
//    On the edge leaving READ, address_b<=0. rd_cnt counts 0..13.
//  - Capture: a valid pipe of RD_LAT flops is fed by (State==READ).
//    When the pipe output is 1, q_b is stored into shadow byte wr_cnt and wr_cnt++.
//    Byte k (k=0..13) is captured at rising edge k+1+RD_LAT after the first run edge.
//  - Shadow layout: bytes 0-5 destination, 6-11 source, 12-13 type. Big-endian, first byte MSB.
//  - CHECK: publish atomically in one edge. oRx_MAC_pc<=src, oRx_Ether_type<=type.
//    oDestMatch<=(dst=={`MAC_Addr0..`MAC_Addr5}), oBroadcast<=(dst==48'hFFFFFFFFFFFF).
//    Published outputs are never partially updated.
//  - END: oRunEnd=1 (Moore). Outputs hold until iRunStart falls.
//  - Latency: oRunEnd high after rising edge 16+RD_LAT (edge 1 = first edge with iRunStart high).
//    Short frame: oRunEnd and oRunErr high after edge 1 and edge 2 respectively? No: both high after edge 1.
//  - Address arithmetic is 10-bit and wraps (ETHER_OFFSET=10'h3FA reads 3FA..3FF,000..007).
//  - iFrameLen is sampled only in IDLE; later changes are ignored.
// TESTING
//  1 RD_LAT=2, RAM header = local MAC, 00:11:22:33:44:55, 08:00 ->
//    oRx_MAC_pc=48'h001122334455, oRx_Ether_type=16'h0800, oDestMatch=1, oBroadcast=0,
//    oRunEnd rises after edge 18.
//  2 Destination FF x6, type 08:06 (ARP) -> oBroadcast=1, oDestMatch=0, oRx_Ether_type=16'h0806.
//  3 iFrameLen=13 -> rden_b never asserted, oRunErr=1, oRunEnd=1 after edge 1, fields stay 0.
//  4 iRunStart dropped after edge 8 -> all outputs 0 same cycle, address_b=0.
//    Re-raise -> full correct parse, no stale bytes.
//  5 ETHER_OFFSET=10'h3FA -> addresses 3FA..3FF,000..007 in order, 14 rden_b cycles exactly.
//  6 RD_LAT=1 and RD_LAT=3 with test-1 data -> same field values; oRunEnd after edge 17 and 19.

Source files
------------

// File: rtl/etherheader_rx_parser.sv
// etherheader_rx_parser
// Reads the 14-byte Ethernet header of a received frame from port B of the RX
// frame RAM. It splits the header into destination MAC, source MAC and
// EtherType, and flags whether the frame is addressed to this station or is a
// broadcast. The source MAC and EtherType are published for the TX header
// writer to use when it builds the reply.

`ifndef MAC_Addr0
`define MAC_Addr0 8'h01
`define MAC_Addr1 8'h60
`define MAC_Addr2 8'h6E
`define MAC_Addr3 8'h11
`define MAC_Addr4 8'h02
`define MAC_Addr5 8'h0F
`endif

module etherheader_rx_parser #(
  parameter logic [9:0]  ETHER_OFFSET = 10'd0,
  parameter int          RD_LAT       = 2,
  parameter logic [47:0] LOCAL_MAC    = {`MAC_Addr0, `MAC_Addr1, `MAC_Addr2,
                                         `MAC_Addr3, `MAC_Addr4, `MAC_Addr5}
) (
  input  logic        iDm9000aClk,
  input  logic        iRunStart,
  input  logic [10:0] iFrameLen,
  input  logic [7:0]  q_b,
  output logic        rden_b,
  output logic [9:0]  address_b,
  output logic [47:0] oRx_MAC_pc,
  output logic [15:0] oRx_Ether_type,
  output logic        oDestMatch,
  output logic        oBroadcast,
  output logic        oRunErr,
  output logic        oRunEnd
);

  localparam logic [3:0]  LAST_BYTE  = 4'd13;
  localparam logic [10:0] HEADER_LEN = 11'd14;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_READ  = 5'b00010,
    ST_DRAIN = 5'b00100,
    ST_CHECK = 5'b01000,
    ST_END   = 5'b10000
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        rd_cnt_q, rd_cnt_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic [9:0]        addr_q, addr_d;
  logic              rden_q, rden_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [7:0]        shadow_q [14];
  logic [7:0]        shadow_d [14];
  logic [47:0]       mac_q, mac_d;
  logic [15:0]       type_q, type_d;
  logic              match_q, match_d;
  logic              bcast_q, bcast_d;
  logic              err_q, err_d;
  logic              end_q, end_d;

  logic              cap_en;
  logic              last_cap;
  logic [47:0]       dst_w;
  logic [47:0]       src_w;
  logic [15:0]       type_w;

  // The tail of the valid pipe marks the cycle when q_b holds the byte that was
  // addressed RD_LAT clocks earlier.
  assign cap_en   = vld_q[RD_LAT-1];
  assign last_cap = cap_en && (wr_cnt_q == LAST_BYTE);

  // Big-endian view of the shadow bytes: the first byte on the wire is the MSB.
  assign dst_w  = {shadow_q[0], shadow_q[1], shadow_q[2],
                   shadow_q[3], shadow_q[4], shadow_q[5]};
  assign src_w  = {shadow_q[6], shadow_q[7], shadow_q[8],
                   shadow_q[9], shadow_q[10], shadow_q[11]};
  assign type_w = {shadow_q[12], shadow_q[13]};

  // Read-data capture: delay the READ indication by the RAM latency and store
  // each returned byte into the next shadow slot.
  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = (state_q == ST_READ);
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    shadow_d = shadow_q;
    wr_cnt_d = wr_cnt_q;
    if (cap_en) begin
      shadow_d[wr_cnt_q] = q_b;
      wr_cnt_d           = wr_cnt_q + 4'd1;
    end
  end

  // Control FSM: issue 14 reads, wait for the last byte to arrive, then
  // publish every field in the same edge so consumers never see a mix.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    addr_d   = addr_q;
    rden_d   = rden_q;
    mac_d    = mac_q;
    type_d   = type_q;
    match_d  = match_q;
    bcast_d  = bcast_q;
    err_d    = err_q;
    end_d    = end_q;
    case (state_q)
      ST_IDLE: begin
        if (iFrameLen >= HEADER_LEN) begin
          state_d  = ST_READ;
          addr_d   = ETHER_OFFSET;
          rd_cnt_d = 4'd0;
          rden_d   = 1'b1;
        end else begin
          state_d = ST_END;
          err_d   = 1'b1;
          end_d   = 1'b1;
        end
      end
      ST_READ: begin
        if (rd_cnt_q == LAST_BYTE) begin
          state_d  = ST_DRAIN;
          addr_d   = 10'd0;
          rd_cnt_d = 4'd0;
          rden_d   = 1'b0;
        end else begin
          addr_d   = addr_q + 10'd1;
          rd_cnt_d = rd_cnt_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (last_cap) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_END;
        mac_d   = src_w;
        type_d  = type_w;
        match_d = (dst_w == LOCAL_MAC);
        bcast_d = (dst_w == 48'hFFFF_FFFF_FFFF);
        end_d   = 1'b1;
      end
      ST_END: begin
        state_d = ST_END;
      end
      default: begin
        state_d = ST_IDLE;
        rden_d  = 1'b0;
        addr_d  = 10'd0;
      end
    endcase
  end

  // State and output registers. A low iRunStart aborts and clears everything at once.
  always_ff @(posedge iDm9000aClk or negedge iRunStart) begin
    if (!iRunStart) begin
      state_q  <= ST_IDLE;
      rd_cnt_q <= 4'd0;
      wr_cnt_q <= 4'd0;
      addr_q   <= 10'd0;
      rden_q   <= 1'b0;
      vld_q    <= '0;
      for (int i = 0; i < 14; i++) begin
        shadow_q[i] <= 8'h00;
      end
      mac_q    <= 48'd0;
      type_q   <= 16'd0;
      match_q  <= 1'b0;
      bcast_q  <= 1'b0;
      err_q    <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      addr_q   <= addr_d;
      rden_q   <= rden_d;
      vld_q    <= vld_d;
      shadow_q <= shadow_d;
      mac_q    <= mac_d;
      type_q   <= type_d;
      match_q  <= match_d;
      bcast_q  <= bcast_d;
      err_q    <= err_d;
      end_q    <= end_d;
    end
  end

  assign rden_b         = rden_q;
  assign address_b      = addr_q;
  assign oRx_MAC_pc     = mac_q;
  assign oRx_Ether_type = type_q;
  assign oDestMatch     = match_q;
  assign oBroadcast     = bcast_q;
  assign oRunErr        = err_q;
  assign oRunEnd        = end_q;

endmodule

// File: tb/tb_etherheader_rx_parser.sv
// Bench for etherheader_rx_parser. Four instances run in lockstep with
// different read latencies and header offsets, each behind its own RAM model.
// Results are compared against a reference derived directly from the header
// bytes.

module tb_etherheader_rx_parser;

  localparam int          NI        = 4;
  localparam logic [47:0] LOCAL_MAC = 48'h01606E11020F;

  function automatic int lat_of(input int g);
    return (g == 1) ? 1 : (g == 2) ? 3 : 2;
  endfunction

  function automatic logic [9:0] off_of(input int g);
    return (g == 3) ? 10'h3FA : 10'h000;
  endfunction

  logic        clk = 1'b0;
  logic        run_start = 1'b0;
  logic [10:0] frame_len = 11'd0;
  logic        mon_clr = 1'b0;

  logic [7:0]  mem     [NI][1024];
  logic [7:0]  rd_pipe [NI][3];
  logic [7:0]  q_b     [NI];
  logic        rden    [NI];
  logic [9:0]  addr    [NI];
  logic [47:0] mac_pc  [NI];
  logic [15:0] etype   [NI];
  logic        dmatch  [NI];
  logic        bcast   [NI];
  logic        rerr    [NI];
  logic        rend    [NI];
  int          rd_cycles [NI];
  logic [9:0]  addr_log  [NI][16];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    etherheader_rx_parser #(
      .ETHER_OFFSET(off_of(gi)),
      .RD_LAT      (lat_of(gi)),
      .LOCAL_MAC   (LOCAL_MAC)
    ) u_dut (
      .iDm9000aClk   (clk),
      .iRunStart     (run_start),
      .iFrameLen     (frame_len),
      .q_b           (q_b[gi]),
      .rden_b        (rden[gi]),
      .address_b     (addr[gi]),
      .oRx_MAC_pc    (mac_pc[gi]),
      .oRx_Ether_type(etype[gi]),
      .oDestMatch    (dmatch[gi]),
      .oBroadcast    (bcast[gi]),
      .oRunErr       (rerr[gi]),
      .oRunEnd       (rend[gi])
    );
  end

  // RAM port-B model: address registered while rden is high, data emerges lat_of(g) clocks later.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rden[g] === 1'b1) rd_pipe[g][0] <= mem[g][addr[g]];
      for (int i = 1; i < 3; i++) rd_pipe[g][i] <= rd_pipe[g][i-1];
    end
  end

  always_comb begin
    for (int g = 0; g < NI; g++) q_b[g] = rd_pipe[g][lat_of(g)-1];
  end

  // Read monitor: counts rden cycles and logs the addresses presented.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (mon_clr) begin
        rd_cycles[g] <= 0;
      end else if (rden[g] === 1'b1) begin
        if (rd_cycles[g] < 16) addr_log[g][rd_cycles[g]] <= addr[g];
        rd_cycles[g] <= rd_cycles[g] + 1;
      end
    end
  end

  task automatic load_header(input logic [111:0] hdr);
    for (int g = 0; g < NI; g++) begin
      for (int i = 0; i < 14; i++) begin
        logic [9:0] a;
        a = off_of(g) + 10'(i);
        mem[g][a] = hdr[111-8*i -: 8];
      end
    end
  endtask

  // One complete parse on all instances, checked against the header-derived reference.
  task automatic do_parse(input string name, input logic [111:0] hdr,
                          input logic [10:0] flen, input bit change_len);
    int          first_end [NI];
    bit          is_short;
    logic [47:0] exp_dst, exp_src;
    logic [15:0] exp_type;
    logic        exp_match, exp_bcast;
    int          exp_edge;
    is_short  = (flen < 11'd14);
    exp_dst   = hdr[111:64];
    exp_src   = is_short ? 48'd0 : hdr[63:16];
    exp_type  = is_short ? 16'd0 : hdr[15:0];
    exp_match = !is_short && (exp_dst == LOCAL_MAC);
    exp_bcast = !is_short && (exp_dst == 48'hFFFFFFFFFFFF);
    $display("parse %s len=%0d hdr=%h", name, flen, hdr);
    load_header(hdr);
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    frame_len = flen;
    run_start = 1'b1;
    for (int g = 0; g < NI; g++) first_end[g] = -1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (change_len && e == 2) frame_len = 11'd3;
      for (int g = 0; g < NI; g++)
        if (rend[g] === 1'b1 && first_end[g] < 0) first_end[g] = e;
    end
    for (int g = 0; g < NI; g++) begin
      exp_edge = is_short ? 1 : 16 + lat_of(g);
      checks++;
      if (first_end[g] != exp_edge)
        $display("FAIL %s[%0d] end_latency: got edge %0d expected edge %0d", name, g, first_end[g], exp_edge);
      else passed++;
      checks++;
      if (mac_pc[g] !== exp_src)
        $display("FAIL %s[%0d] src_mac: got %h expected %h", name, g, mac_pc[g], exp_src);
      else passed++;
      checks++;
      if (etype[g] !== exp_type)
        $display("FAIL %s[%0d] ether_type: got %h expected %h", name, g, etype[g], exp_type);
      else passed++;
      checks++;
      if (dmatch[g] !== exp_match)
        $display("FAIL %s[%0d] dest_match: got %b expected %b", name, g, dmatch[g], exp_match);
      else passed++;
      checks++;
      if (bcast[g] !== exp_bcast)
        $display("FAIL %s[%0d] broadcast: got %b expected %b", name, g, bcast[g], exp_bcast);
      else passed++;
      checks++;
      if (rerr[g] !== is_short)
        $display("FAIL %s[%0d] run_err: got %b expected %b", name, g, rerr[g], is_short);
      else passed++;
      checks++;
      if (rd_cycles[g] != (is_short ? 0 : 14))
        $display("FAIL %s[%0d] rden_cycles: got %0d expected %0d", name, g, rd_cycles[g], is_short ? 0 : 14);
      else passed++;
      if (!is_short) begin
        int bad_idx;
        bad_idx = -1;
        for (int i = 13; i >= 0; i--)
          if (addr_log[g][i] !== off_of(g) + 10'(i)) bad_idx = i;
        checks++;
        if (bad_idx >= 0)
          $display("FAIL %s[%0d] addr_seq: read %0d got %h expected %h", name, g, bad_idx,
                   addr_log[g][bad_idx], off_of(g) + 10'(bad_idx));
        else passed++;
      end
    end
    run_start = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if ({rden[g], addr[g], mac_pc[g], etype[g], dmatch[g], bcast[g], rerr[g], rend[g]} !== '0)
        $display("FAIL %s[%0d] clear_on_stop: got end=%b mac=%h type=%h expected all zero",
                 name, g, rend[g], mac_pc[g], etype[g]);
      else passed++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    run_start = 1'b0;
    frame_len = 11'd64;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      checks++;
      if ({rden[g], addr[g], mac_pc[g], etype[g], dmatch[g], bcast[g], rerr[g], rend[g]} !== '0)
        $display("FAIL reset[%0d] outputs: got rden=%b addr=%h end=%b err=%b expected all zero",
                 g, rden[g], addr[g], rend[g], rerr[g]);
      else passed++;
    end
  endtask

  task automatic test_unicast();
    do_parse("unicast", {LOCAL_MAC, 48'h001122334455, 16'h0800}, 11'd60, 1'b0);
  endtask

  task automatic test_broadcast();
    logic [47:0] src;
    src = {16'($urandom), $urandom};
    do_parse("broadcast", {48'hFFFFFFFFFFFF, src, 16'h0806}, 11'd60, 1'b0);
  endtask

  task automatic test_short();
    do_parse("short13", {LOCAL_MAC, 48'h0A0B0C0D0E0F, 16'h0800}, 11'd13, 1'b0);
    do_parse("short0", {48'hFFFFFFFFFFFF, 48'h0A0B0C0D0E0F, 16'h0806}, 11'd0, 1'b0);
  endtask

  task automatic test_min_len();
    // Exactly 14 bytes, and the length input collapses mid-parse; only the IDLE sample counts.
    do_parse("len14", {LOCAL_MAC, 48'hA1B2C3D4E5F6, 16'h86DD}, 11'd14, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      logic [47:0] dst, src;
      logic [15:0] ty;
      logic [10:0] flen;
      case ($urandom_range(0, 3))
        0:       dst = LOCAL_MAC;
        1:       dst = 48'hFFFFFFFFFFFF;
        2:       dst = LOCAL_MAC ^ (48'd1 << $urandom_range(0, 47));
        default: dst = {16'($urandom), $urandom};
      endcase
      src  = {16'($urandom), $urandom};
      ty   = 16'($urandom);
      flen = 11'($urandom_range(14, 1518));
      do_parse("random", {dst, src, ty}, flen, 1'b0);
    end
  endtask

  task automatic test_abort();
    load_header({48'hFFFFFFFFFFFF, 48'h111111111111, 16'h1111});
    frame_len = 11'd60;
    @(negedge clk);
    run_start = 1'b1;
    repeat (8) @(posedge clk);
    #2 run_start = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if ({rden[g], addr[g], mac_pc[g], etype[g], dmatch[g], bcast[g], rerr[g], rend[g]} !== '0)
        $display("FAIL abort[%0d] outputs: got rden=%b addr=%h end=%b expected all zero",
                 g, rden[g], addr[g], rend[g]);
      else passed++;
    end
    @(negedge clk);
    do_parse("after_abort", {LOCAL_MAC, 48'h5A5A00FF1234, 16'h88CC}, 11'd100, 1'b0);
  endtask

  initial begin
    for (int g = 0; g < NI; g++)
      for (int i = 0; i < 1024; i++) mem[g][i] = 8'($urandom);
    test_reset();
    test_unicast();
    test_broadcast();
    test_short();
    test_min_len();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
